instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word at a time from instruction memory,
// holds it for decode, and advances the PC (sequential or branch) on consume.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        dec_ready,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc_out,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, ERROR} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] pc;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    always_comb begin
        br_off  = {{14{branch_imm[15]}}, branch_imm, 2'b00};
        next_pc = pc + 32'd4 + (branch_taken ? br_off : '0);
    end

    // Output flags are registered alongside the state so they change on the
    // same edge as the state transition that implies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            cnt         <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        cnt         <= '0;
                        state       <= VALID;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state     <= ERROR;
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                VALID: begin
                    if (dec_ready) begin
                        pc          <= next_pc;
                        state       <= FETCH;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];

endmodule
